// File: rtl/l2_ecc_mon_pkg.sv
// rtl/l2_ecc_mon_pkg.sv - shared types, defaults and saturating add for the L2 ECC error monitor
package l2_ecc_mon_pkg;

  typedef enum logic {
    ECC_CH_R = 1'b0,
    ECC_CH_B = 1'b1
  } ecc_chan_e;

  localparam int unsigned DefaultCntWidth = 16;

  // Adds b to a and clamps the result to the all-ones value of a w-bit counter (w <= 32)
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max;
    max = (33'd1 << w) - 33'd1;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > max) begin
      return max[31:0];
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/l2_ecc_err_mon_if.sv
// rtl/l2_ecc_err_mon_if.sv - snooped R/B response handshakes, IDs and ECC user bits of the L2 ports
interface l2_ecc_err_mon_if #(
  parameter int unsigned NumPort    = 2,
  parameter int unsigned AxiIdWidth = 5
);

  logic [NumPort-1:0]                 r_hs;
  logic [NumPort-1:0][AxiIdWidth-1:0] r_id;
  logic [NumPort-1:0]                 r_err;
  logic [NumPort-1:0]                 b_hs;
  logic [NumPort-1:0][AxiIdWidth-1:0] b_id;
  logic [NumPort-1:0]                 b_err;

  modport master (
    output r_hs, r_id, r_err, b_hs, b_id, b_err
  );

  modport slave (
    input r_hs, r_id, r_err, b_hs, b_id, b_err
  );

endinterface

// File: rtl/l2_ecc_log_fifo.sv
// rtl/l2_ecc_log_fifo.sv - register-based synchronous FIFO with generic entry type, no fall-through
module l2_ecc_log_fifo #(
  parameter int unsigned LogDepth = 3,
  parameter type         entry_t  = logic [7:0]
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output entry_t data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned Depth = 1 << LogDepth;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [LogDepth:0] wptr_q, wptr_d;
  logic [LogDepth:0] rptr_q, rptr_d;
  entry_t            mem_q [Depth];
  logic              push_en;
  logic              pop_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[LogDepth-1:0] == rptr_q[LogDepth-1:0]) &&
                   (wptr_q[LogDepth] != rptr_q[LogDepth]);

  // A pop frees a slot in the same cycle, so a push into a full FIFO is taken when popping
  assign pop_en  = pop_i & ~empty_o;
  assign push_en = push_i & (~full_o | pop_en);

  assign wptr_d = wptr_q + {{LogDepth{1'b0}}, push_en};
  assign rptr_d = rptr_q + {{LogDepth{1'b0}}, pop_en};

  assign data_o = mem_q[rptr_q[LogDepth-1:0]];

  // Pointer advance and entry write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (push_en) begin
        mem_q[wptr_q[LogDepth-1:0]] <= data_i;
      end
    end
  end

endmodule

// File: rtl/l2_ecc_err_mon.sv
// rtl/l2_ecc_err_mon.sv - L2 ECC error monitor: counters, sticky flag, irq; log FIFO under L2_ECC_MON_LOG_EN
module l2_ecc_err_mon
  import l2_ecc_mon_pkg::*;
#(
  parameter int unsigned NumPort    = 2,
  parameter int unsigned AxiIdWidth = 5,
  parameter int unsigned LogDepth   = 3,
  parameter int unsigned CntWidth   = DefaultCntWidth,
  localparam int unsigned PortW     = (NumPort > 1) ? $clog2(NumPort) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  l2_ecc_err_mon_if.slave       snoop_if,
  input  logic                  clear_i,
  output logic                  ecc_error_o,
  output logic                  irq_o,
  output logic [CntWidth-1:0]   err_cnt_o,
  output logic [CntWidth-1:0]   drop_cnt_o,
  output logic                  log_valid_o,
  input  logic                  log_ready_i,
  output logic [PortW-1:0]      log_port_o,
  output logic                  log_chan_o,
  output logic [AxiIdWidth-1:0] log_id_o
);

  logic [NumPort-1:0]  evt_r;
  logic [NumPort-1:0]  evt_b;
  logic                any_evt;
  logic [31:0]         evt_cnt;
  logic [31:0]         drop_inc;

  logic [CntWidth-1:0] err_cnt_q, err_cnt_d;
  logic [CntWidth-1:0] drop_cnt_q, drop_cnt_d;
  logic                ecc_q, ecc_d;
  logic                irq_q, irq_d;

  // Decode this cycle's error beats and count them
  always_comb begin
    evt_r   = snoop_if.r_hs & snoop_if.r_err;
    evt_b   = snoop_if.b_hs & snoop_if.b_err;
    any_evt = |{evt_r, evt_b};
    evt_cnt = '0;
    for (int p = 0; p < NumPort; p++) begin
      evt_cnt = evt_cnt + 32'(evt_r[p]) + 32'(evt_b[p]);
    end
  end

`ifdef L2_ECC_MON_LOG_EN
  typedef struct packed {
    logic [PortW-1:0]      port;
    ecc_chan_e             chan;
    logic [AxiIdWidth-1:0] id;
  } log_entry_t;

  log_entry_t sel_entry;
  log_entry_t head_entry;
  logic       sel_found;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       push_acc;

  // Pick one event to log: lowest port first, R before B within a port
  always_comb begin
    sel_found = 1'b0;
    sel_entry = '0;
    for (int p = 0; p < NumPort; p++) begin
      if (!sel_found && evt_r[p]) begin
        sel_found      = 1'b1;
        sel_entry.port = PortW'(p);
        sel_entry.chan = ECC_CH_R;
        sel_entry.id   = snoop_if.r_id[p];
      end
      if (!sel_found && evt_b[p]) begin
        sel_found      = 1'b1;
        sel_entry.port = PortW'(p);
        sel_entry.chan = ECC_CH_B;
        sel_entry.id   = snoop_if.b_id[p];
      end
    end
  end

  assign pop      = ~fifo_empty & log_ready_i;
  assign push_acc = sel_found & (~fifo_full | pop);
  assign drop_inc = evt_cnt - 32'(push_acc);

  l2_ecc_log_fifo #(
    .LogDepth (LogDepth),
    .entry_t  (log_entry_t)
  ) u_log_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (sel_found),
    .data_i  (sel_entry),
    .pop_i   (log_ready_i),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign log_valid_o = ~fifo_empty;
  assign log_port_o  = head_entry.port;
  assign log_chan_o  = head_entry.chan;
  assign log_id_o    = head_entry.id;
`else
  // Without the log every event is a drop; IDs and the pop strobe have no consumer
  logic unused_log_inputs;
  assign unused_log_inputs = ^{snoop_if.r_id, snoop_if.b_id, log_ready_i};

  assign drop_inc    = evt_cnt;
  assign log_valid_o = 1'b0;
  assign log_port_o  = '0;
  assign log_chan_o  = 1'b0;
  assign log_id_o    = '0;
`endif

  // Clear zeroes the base values; this cycle's events are then applied on top
  always_comb begin
    err_cnt_d  = CntWidth'(sat_add(clear_i ? 32'd0 : 32'(err_cnt_q), evt_cnt, CntWidth));
    drop_cnt_d = CntWidth'(sat_add(clear_i ? 32'd0 : 32'(drop_cnt_q), drop_inc, CntWidth));
    ecc_d      = (ecc_q & ~clear_i) | any_evt;
    irq_d      = any_evt;
  end

  // Counter, sticky flag and irq registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ecc_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ecc_q      <= ecc_d;
      irq_q      <= irq_d;
    end
  end

  assign err_cnt_o   = err_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
  assign ecc_error_o = ecc_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_l2_ecc_err_mon.sv
// tb/tb_l2_ecc_err_mon.sv - table-driven self-checking bench for l2_ecc_err_mon (both L2_ECC_MON_LOG_EN builds)
`timescale 1ns/1ps
module tb_l2_ecc_err_mon;
  import l2_ecc_mon_pkg::*;

  localparam int NP = 2;
  localparam int IW = 5;
  localparam int LD = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          rdy;
  logic          ecc;
  logic          irq;
  logic [CW-1:0] errc;
  logic [CW-1:0] dropc;
  logic          lv;
  logic [0:0]    lport;
  logic          lchan;
  logic [IW-1:0] lid;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  l2_ecc_err_mon_if #(.NumPort(NP), .AxiIdWidth(IW)) snoop ();

  l2_ecc_err_mon #(
    .NumPort    (NP),
    .AxiIdWidth (IW),
    .LogDepth   (LD),
    .CntWidth   (CW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .snoop_if    (snoop),
    .clear_i     (clear),
    .ecc_error_o (ecc),
    .irq_o       (irq),
    .err_cnt_o   (errc),
    .drop_cnt_o  (dropc),
    .log_valid_o (lv),
    .log_ready_i (rdy),
    .log_port_o  (lport),
    .log_chan_o  (lchan),
    .log_id_o    (lid)
  );

  typedef struct {
    string       name;
    logic [1:0]  r_hs, r_err, b_hs, b_err;
    logic [4:0]  rid0, rid1, bid0, bid1;
    logic        clr, rdy;
    logic [15:0] e_err, e_drop_log, e_drop_nolog;
    logic        e_flag, e_irq, e_lv, e_port, e_chan;
    logic [4:0]  e_id;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic void addv(input string name,
                               input logic [1:0] rhs, rerr, bhs, berr,
                               input logic [4:0] rid0, rid1, bid0, bid1,
                               input logic clr, rd,
                               input logic [15:0] e_err, e_dl, e_dn,
                               input logic e_flag, e_irq, e_lv, e_port, e_chan,
                               input logic [4:0] e_id);
    vec_t v;
    v.name = name; v.r_hs = rhs; v.r_err = rerr; v.b_hs = bhs; v.b_err = berr;
    v.rid0 = rid0; v.rid1 = rid1; v.bid0 = bid0; v.bid1 = bid1;
    v.clr = clr; v.rdy = rd;
    v.e_err = e_err; v.e_drop_log = e_dl; v.e_drop_nolog = e_dn;
    v.e_flag = e_flag; v.e_irq = e_irq; v.e_lv = e_lv;
    v.e_port = e_port; v.e_chan = e_chan; v.e_id = e_id;
    vq.push_back(v);
  endfunction

  task automatic set_idle();
    snoop.r_hs = '0; snoop.r_err = '0; snoop.r_id = '0;
    snoop.b_hs = '0; snoop.b_err = '0; snoop.b_id = '0;
    clear = 1'b0; rdy = 1'b0;
  endtask

  // Apply inputs for one clock, then sample 1ns after the edge with inputs back at idle
  task automatic drive(input logic [1:0] rhs, rerr, bhs, berr,
                       input logic [4:0] rid0, rid1, bid0, bid1,
                       input logic clr, rd);
    snoop.r_hs = rhs; snoop.r_err = rerr; snoop.r_id = {rid1, rid0};
    snoop.b_hs = bhs; snoop.b_err = berr; snoop.b_id = {bid1, bid0};
    clear = clr; rdy = rd;
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic check_counts(input string name, input logic [15:0] e_err,
                              input logic [15:0] e_dl, input logic [15:0] e_dn,
                              input logic e_flag, input logic e_irq);
    logic [15:0] e_drop;
`ifdef L2_ECC_MON_LOG_EN
    e_drop = e_dl;
`else
    e_drop = e_dn;
`endif
    chk({name, ".err_cnt"}, errc, e_err);
    chk({name, ".drop_cnt"}, dropc, e_drop);
    chk({name, ".ecc_error"}, ecc, e_flag);
    chk({name, ".irq"}, irq, e_irq);
  endtask

  task automatic check_log(input string name, input logic e_lv, input logic e_port,
                           input logic e_chan, input logic [4:0] e_id);
`ifdef L2_ECC_MON_LOG_EN
    chk({name, ".log_valid"}, lv, e_lv);
    if (e_lv) begin
      chk({name, ".log_port"}, lport, e_port);
      chk({name, ".log_chan"}, lchan, e_chan);
      chk({name, ".log_id"}, lid, e_id);
    end
`else
    chk({name, ".log_valid"}, lv, 1'b0);
    chk({name, ".log_head"}, {lport, lchan, lid}, 7'd0);
`endif
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_counts("reset", 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    chk("reset.log_valid", lv, 1'b0);
    chk("reset.log_head", {lport, lchan, lid}, 7'd0);
    rst_n = 1'b1;

    //     name        r_hs   r_err  b_hs   b_err  rid0   rid1   bid0   bid1   clr rdy err    drop_l drop_n f  i  lv p  c  id
    addv("idle",      2'b00, 2'b00, 2'b00, 2'b00, 5'h00, 5'h00, 5'h00, 5'h00, 0, 0, 16'd0, 16'd0, 16'd0, 0, 0, 0, 0, 0, 5'h00);
    addv("r_p0",      2'b01, 2'b01, 2'b00, 2'b00, 5'h13, 5'h00, 5'h00, 5'h00, 0, 0, 16'd1, 16'd0, 16'd1, 1, 1, 1, 0, 0, 5'h13);
    addv("hold",      2'b00, 2'b00, 2'b00, 2'b00, 5'h00, 5'h00, 5'h00, 5'h00, 0, 0, 16'd1, 16'd0, 16'd1, 1, 0, 1, 0, 0, 5'h13);
    addv("hs_noerr",  2'b10, 2'b00, 2'b11, 2'b00, 5'h01, 5'h02, 5'h03, 5'h04, 0, 0, 16'd1, 16'd0, 16'd1, 1, 0, 1, 0, 0, 5'h13);
    addv("err_nohs",  2'b00, 2'b11, 2'b00, 2'b11, 5'h01, 5'h02, 5'h03, 5'h04, 0, 0, 16'd1, 16'd0, 16'd1, 1, 0, 1, 0, 0, 5'h13);
    addv("two_evt",   2'b10, 2'b10, 2'b01, 2'b01, 5'h00, 5'h07, 5'h03, 5'h00, 0, 0, 16'd3, 16'd1, 16'd3, 1, 1, 1, 0, 0, 5'h13);
    addv("pop1",      2'b00, 2'b00, 2'b00, 2'b00, 5'h00, 5'h00, 5'h00, 5'h00, 0, 1, 16'd3, 16'd1, 16'd3, 1, 0, 1, 0, 1, 5'h03);
    addv("pop2",      2'b00, 2'b00, 2'b00, 2'b00, 5'h00, 5'h00, 5'h00, 5'h00, 0, 1, 16'd3, 16'd1, 16'd3, 1, 0, 0, 0, 0, 5'h00);
    addv("clr",       2'b00, 2'b00, 2'b00, 2'b00, 5'h00, 5'h00, 5'h00, 5'h00, 1, 0, 16'd0, 16'd0, 16'd0, 0, 0, 0, 0, 0, 5'h00);
    addv("clr_evt",   2'b00, 2'b00, 2'b10, 2'b10, 5'h00, 5'h00, 5'h00, 5'h1F, 1, 0, 16'd1, 16'd0, 16'd1, 1, 1, 1, 1, 1, 5'h1F);
    addv("r_p1",      2'b10, 2'b10, 2'b00, 2'b00, 5'h00, 5'h05, 5'h00, 5'h00, 0, 0, 16'd2, 16'd0, 16'd2, 1, 1, 1, 1, 1, 5'h1F);
    addv("four",      2'b11, 2'b11, 2'b11, 2'b11, 5'h01, 5'h02, 5'h04, 5'h08, 0, 0, 16'd6, 16'd3, 16'd6, 1, 1, 1, 1, 1, 5'h1F);
    addv("clr_keep",  2'b00, 2'b00, 2'b00, 2'b00, 5'h00, 5'h00, 5'h00, 5'h00, 1, 0, 16'd0, 16'd0, 16'd0, 0, 0, 1, 1, 1, 5'h1F);
    addv("pop_a",     2'b00, 2'b00, 2'b00, 2'b00, 5'h00, 5'h00, 5'h00, 5'h00, 0, 1, 16'd0, 16'd0, 16'd0, 0, 0, 1, 1, 0, 5'h05);
    addv("pop_b",     2'b00, 2'b00, 2'b00, 2'b00, 5'h00, 5'h00, 5'h00, 5'h00, 0, 1, 16'd0, 16'd0, 16'd0, 0, 0, 1, 0, 0, 5'h01);
    addv("pop_c",     2'b00, 2'b00, 2'b00, 2'b00, 5'h00, 5'h00, 5'h00, 5'h00, 0, 1, 16'd0, 16'd0, 16'd0, 0, 0, 0, 0, 0, 5'h00);

    foreach (vq[i]) begin
      drive(vq[i].r_hs, vq[i].r_err, vq[i].b_hs, vq[i].b_err,
            vq[i].rid0, vq[i].rid1, vq[i].bid0, vq[i].bid1, vq[i].clr, vq[i].rdy);
      check_counts(vq[i].name, vq[i].e_err, vq[i].e_drop_log, vq[i].e_drop_nolog,
                   vq[i].e_flag, vq[i].e_irq);
      check_log(vq[i].name, vq[i].e_lv, vq[i].e_port, vq[i].e_chan, vq[i].e_id);
    end

    // Fill the 8-entry log with 9 single errors, then push into a full FIFO while popping
    for (int i = 0; i < 9; i++) begin
      drive(2'b01, 2'b01, 2'b00, 2'b00, 5'(i), 5'h00, 5'h00, 5'h00, 1'b0, 1'b0);
    end
    check_counts("fill", 16'd9, 16'd1, 16'd9, 1'b1, 1'b1);
    check_log("fill", 1'b1, 1'b0, 1'b0, 5'h00);
    drive(2'b01, 2'b01, 2'b00, 2'b00, 5'h1A, 5'h00, 5'h00, 5'h00, 1'b0, 1'b1);
    check_counts("full_pop_push", 16'd10, 16'd1, 16'd10, 1'b1, 1'b1);
    check_log("full_pop_push", 1'b1, 1'b0, 1'b0, 5'h01);
    for (int k = 0; k < 8; k++) begin
      logic [4:0] e_id;
      e_id = (k < 6) ? 5'(k + 2) : 5'h1A;
      drive(2'b00, 2'b00, 2'b00, 2'b00, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0, 1'b1);
      check_log($sformatf("drain%0d", k), (k < 7), 1'b0, 1'b0, e_id);
    end

    // Drive the counters to saturation with the log popped every cycle
    drive(2'b00, 2'b00, 2'b00, 2'b00, 5'h00, 5'h00, 5'h00, 5'h00, 1'b1, 1'b0);
    check_counts("sat_clr", 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16383; i++) begin
      drive(2'b11, 2'b11, 2'b11, 2'b11, 5'h01, 5'h02, 5'h03, 5'h04, 1'b0, 1'b1);
    end
    check_counts("sat_pre", 16'hFFFC, 16'd49149, 16'hFFFC, 1'b1, 1'b1);
    drive(2'b01, 2'b01, 2'b10, 2'b10, 5'h01, 5'h00, 5'h00, 5'h04, 1'b0, 1'b1);
    check_counts("sat_fffe", 16'hFFFE, 16'd49150, 16'hFFFE, 1'b1, 1'b1);
    drive(2'b01, 2'b01, 2'b10, 2'b10, 5'h01, 5'h00, 5'h00, 5'h04, 1'b0, 1'b1);
    check_counts("sat_ffff", 16'hFFFF, 16'd49151, 16'hFFFF, 1'b1, 1'b1);
    drive(2'b01, 2'b01, 2'b10, 2'b10, 5'h01, 5'h00, 5'h00, 5'h04, 1'b0, 1'b1);
    check_counts("sat_hold", 16'hFFFF, 16'd49152, 16'hFFFF, 1'b1, 1'b1);
    check_log("sat_hold", 1'b1, 1'b0, 1'b0, 5'h01);

    // Asynchronous reset between clock edges clears everything at once
    #2 rst_n = 1'b0;
    #1;
    check_counts("async_rst", 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    chk("async_rst.log_valid", lv, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/l2_ecc_err_mon.md
# l2_ecc_err_mon

ECC error monitor on the L2 response path, one per L2 memory wrapper. It snoops the R and B channels of every synchronous L2 AXI port, after the destination CDC and before the responses are handed back. A beat counts as an ECC error when its AXI user error bit is set. The block counts these beats, keeps a sticky error flag that drives the wrapper's `ecc_error_o` (today tied to 0), and optionally logs the ID and channel of each error into a small FIFO for software.

## Interface
Parameters:
- `NumPort`, 2, number of monitored L2 AXI ports
- `AxiIdWidth`, 5, AXI ID width
- `LogDepth`, 3, log FIFO depth is 2**LogDepth entries
- `CntWidth`, 16, width of each saturating counter

Ports:
- `clk_i`  in  1  L2 clock (single clock domain)
- `rst_ni`  in  1  asynchronous active-low reset
- `r_hs_i`  in  NumPort  R beat handshake (`r_valid & r_ready`) per port
- `r_id_i`  in  NumPort x AxiIdWidth  R ID per port
- `r_err_i`  in  NumPort  R user ECC error bit per port
- `b_hs_i`  in  NumPort  B handshake per port
- `b_id_i`  in  NumPort x AxiIdWidth  B ID per port
- `b_err_i`  in  NumPort  B user ECC error bit per port
- `clear_i`  in  1  single-cycle pulse; clears counters and the sticky flag
- `ecc_error_o`  out  1  sticky error flag
- `irq_o`  out  1  one-cycle pulse per cycle containing at least one error
- `err_cnt_o`  out  CntWidth  total errors seen, saturating
- `drop_cnt_o`  out  CntWidth  errors not logged, saturating
- `log_valid_o`  out  1  log FIFO not empty
- `log_ready_i`  in  1  log pop; an entry is popped when `log_valid_o & log_ready_i`
- `log_port_o`  out  max(1,$clog2(NumPort))  port of the head entry
- `log_chan_o`  out  1  channel of the head entry: 0 = R, 1 = B
- `log_id_o`  out  AxiIdWidth  AXI ID of the head entry

## Operation
- Error event: any `r_hs_i[p] & r_err_i[p]` or `b_hs_i[p] & b_err_i[p]`. Up to 2*NumPort events can occur per cycle.
- `err_cnt_o` adds the popcount of the cycle's events and saturates at all-ones.
- At most one event is captured per cycle, chosen by a fixed priority:
  - lower port index first;
  - within a port, R before B.
- Every event that is not captured increments `drop_cnt_o`, saturating. This includes the other events in a multi-event cycle and the captured event when the FIFO is full with no pop in that cycle.
- FIFO full with a pop in the same cycle: the push is accepted.
- FIFO empty: a push in the same cycle is not visible on the outputs until the next cycle. There is no fall-through.
- `ecc_error_o` is set on any event and stays set until `clear_i`.
- `clear_i` handling:
  - zeroes `err_cnt_o`, `drop_cnt_o` and `ecc_error_o`;
  - events in the same cycle are then applied on top of the cleared values, so the flag is 1 and the counts equal that cycle's counts;
  - does not flush the log FIFO.
- No state machine. State is counters, sticky flag, irq register, FIFO pointers and the FIFO array.

## Timing
- All outputs are registered.
- Reset values: `ecc_error_o`=0, `irq_o`=0, `err_cnt_o`=0, `drop_cnt_o`=0, `log_valid_o`=0, `log_port_o`/`log_chan_o`/`log_id_o`=0.
- An event in cycle N is reflected in the counters, flag and `irq_o` in cycle N+1, and in `log_valid_o` in N+1 when the FIFO was empty.
- `irq_o` is high for exactly one cycle per event cycle. Back-to-back event cycles give a continuously high `irq_o`.
- Log head outputs are stable while `log_valid_o & !log_ready_i`.
- FIFO pointers are LogDepth+1 bits with wrap-around. Full means equal indices with differing MSB.
- Asserting reset mid-operation clears everything immediately. Events in flight are lost.

## Configuration
- `L2_ECC_MON_LOG_EN` defined: the log FIFO and `log_*` ports are functional.
- Not defined:
  - no FIFO storage is generated;
  - `log_valid_o`, `log_port_o`, `log_chan_o` and `log_id_o` are tied to 0;
  - `log_ready_i` is ignored;
  - every event is counted in both `err_cnt_o` and `drop_cnt_o`.
- Counters, flag and irq behave identically in both builds.

## Structure
- Package `l2_ecc_mon_pkg`:
  - `ecc_chan_e` enum: `ECC_CH_R`=0, `ECC_CH_B`=1;
  - default `CntWidth`;
  - a saturating-add function.
- The log entry struct is local, because it depends on the parameters.
- Sub-module `l2_ecc_log_fifo`: register-based synchronous FIFO with push/pop and full/empty flags, generic entry type.

## Test plan
- Single R error on port 0, ID 0x13 -> next cycle `err_cnt_o`=1, `ecc_error_o`=1, `irq_o` pulses once; log head is port 0, chan R, ID 0x13.
- Same cycle: port0 B error ID 3 and port1 R error ID 7 -> `err_cnt_o`=2, `drop_cnt_o`=1, logged entry is port 0, chan B, ID 3.
- 9 single-error cycles with no pops (LogDepth=3) -> 8 entries, `drop_cnt_o`=1. Pop and push in the same full cycle -> accepted, `drop_cnt_o` stays 1.
- Force `err_cnt_o` to 0xFFFE, then one cycle with 2 events -> 0xFFFF and it holds.
- `clear_i` in the same cycle as 1 event -> `err_cnt_o`=1, flag=1. `clear_i` alone -> counts 0, flag 0, FIFO contents retained.
- Build without `L2_ECC_MON_LOG_EN`, 3 events -> `log_valid_o` stays 0, `err_cnt_o`=3, `drop_cnt_o`=3.
